// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative RV32M/RV64M multiply/divide unit.
// One shift-add (multiply) / restoring shift-subtract (divide) step per cycle
// over unsigned magnitudes, followed by a single sign-fix cycle.
module muldiv_iter #(
  parameter int unsigned XLEN      = 32,
  parameter bit          EARLY_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] r1,
  input  logic [XLEN-1:0] r2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rd,
  output logic            busy
);

  localparam int unsigned CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;
  typedef enum logic [2:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } op_e;

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic                s1_q, s1_d;
  logic                s2_q, s2_d;
  logic                dz_q, dz_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;   // mul: {partial product, multiplier}; div: {remainder, quotient}
  logic [XLEN-1:0]     opb_q, opb_d;   // multiplicand or divisor magnitude
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [XLEN-1:0]     rd_q, rd_d;

  // Request decode, operand magnitudes and accept-time special cases
  op_e             op_in;
  logic            in_is_div, sign1, sign2, r1_zero, r2_zero, special;
  logic [XLEN-1:0] mag1, mag2, special_val;

  always_comb begin
    op_in       = op_e'(op);
    in_is_div   = op_in inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    sign1       = (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && r1[XLEN-1];
    sign2       = (op_in inside {OP_MULH, OP_DIV, OP_REM}) && r2[XLEN-1];
    mag1        = sign1 ? -r1 : r1;
    mag2        = sign2 ? -r2 : r2;
    r1_zero     = (r1 == '0);
    r2_zero     = (r2 == '0);
    special     = 1'b0;
    special_val = '0;
    if (!in_is_div) begin
      special = r1_zero || r2_zero;
    end else if (r2_zero) begin
      special     = 1'b1;
      special_val = (op_in inside {OP_REM, OP_REMU}) ? r1 : '1;
    end else if ((op_in inside {OP_DIV, OP_REM}) && (r1 == MIN_NEG) && (&r2)) begin
      special     = 1'b1;
      special_val = (op_in == OP_REM) ? '0 : r1;
    end
  end

  // One iteration of the shift-add multiply and restoring divide datapaths
  logic [XLEN:0]     mul_sum, div_sh, div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] mul_next, div_next;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    div_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff = div_sh - {1'b0, opb_q};
    // The partial remainder stays below the divisor (or below 2^XLEN when
    // dividing by zero), so no borrow out of the top bit means "fits".
    div_ge   = ~div_diff[XLEN];
    div_next = {div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0], acc_q[XLEN-2:0], div_ge};
  end

  // Sign correction and result selection for the FIX cycle
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, result;
  logic              is_div_q;

  always_comb begin
    is_div_q = op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    prod_fix = (s1_q ^ s2_q) ? -acc_q : acc_q;
    // Divide-by-zero must yield all ones regardless of the dividend sign.
    quo_fix  = dz_q ? '1 : ((s1_q ^ s2_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0]);
    rem_fix  = s1_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:                        result = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  result = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               result = quo_fix;
      default:                       result = rem_fix;
    endcase
  end

  // Next-state and datapath register update
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    dz_d    = dz_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_d  = op_in;
            s1_d  = sign1;
            s2_d  = sign2;
            dz_d  = in_is_div && r2_zero;
            cnt_d = CW'(XLEN);
            if (in_is_div) begin
              acc_d = {{XLEN{1'b0}}, mag1};
              opb_d = mag2;
            end else begin
              acc_d = {{XLEN{1'b0}}, mag2};
              opb_d = mag1;
            end
            if (EARLY_OUT && special) begin
              state_d = S_DONE;
              rd_d    = special_val;
            end else begin
              state_d = S_CALC;
            end
          end
        end
        S_CALC: begin
          acc_d = is_div_q ? div_next : mul_next;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = S_FIX;
        end
        S_FIX: begin
          rd_d    = result;
          state_d = S_DONE;
        end
        S_DONE: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_MUL;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      dz_q    <= 1'b0;
      acc_q   <= '0;
      opb_q   <= '0;
      cnt_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      dz_q    <= dz_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign rd        = rd_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// tb_muldiv_iter: directed and random checks of muldiv_iter against an
// arithmetic reference model. Instance 0 has EARLY_OUT=1, instance 1 EARLY_OUT=0.
module tb_muldiv_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv[2], ir[2], fl[2], ov[2], ordy[2], bz[2];
  logic [2:0]  opv[2];
  logic [31:0] ra[2], rb[2], rdv[2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_iter #(.XLEN(32), .EARLY_OUT(1'b1)) u_fast (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .op(opv[0]),
    .r1(ra[0]), .r2(rb[0]), .flush(fl[0]), .out_valid(ov[0]),
    .out_ready(ordy[0]), .rd(rdv[0]), .busy(bz[0])
  );

  muldiv_iter #(.XLEN(32), .EARLY_OUT(1'b0)) u_slow (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .op(opv[1]),
    .r1(ra[1]), .r2(rb[1]), .flush(fl[1]), .out_valid(ov[1]),
    .out_ready(ordy[1]), .rd(rdv[1]), .busy(bz[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: RISC-V M-extension results from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (o)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
      3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o < 3'd4) return (a == 0) || (b == 0);
    if (b == 0) return 1'b1;
    return (o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  // Issue one op on instance s, wait for its result, check latency and rd, hand off.
  task automatic run_op(input int s, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input string tag);
    logic [31:0] exp;
    int exp_lat, lat;
    exp     = ref_res(o, a, b);
    exp_lat = (s == 0 && is_special(o, a, b)) ? 1 : 34;
    @(negedge clk);
    check($sformatf("%s/in_ready", tag), {31'b0, ir[s]}, 32'd1);
    iv[s] = 1'b1; opv[s] = o; ra[s] = a; rb[s] = b;
    @(posedge clk);
    @(negedge clk);
    iv[s] = 1'b0;
    lat = 1;
    while (!ov[s] && lat < 100) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check($sformatf("%s/latency", tag), lat, exp_lat);
    check($sformatf("%s/rd", tag), rdv[s], exp);
    ordy[s] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ordy[s] = 1'b0;
    check($sformatf("%s/handoff", tag), {30'b0, ov[s], ir[s]}, 32'd1);
  endtask

  // Start an op on instance 0 and return at the negedge N cycles into CALC.
  task automatic start_and_wait(input logic [2:0] o, input logic [31:0] a,
                                input logic [31:0] b, input int n);
    @(negedge clk);
    iv[0] = 1'b1; opv[0] = o; ra[0] = a; rb[0] = b;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (n - 1) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    logic [2:0]  o;
    logic [31:0] a, b, hold_rd;
    int          seen;

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      iv[i] = 1'b0; fl[i] = 1'b0; ordy[i] = 1'b0; opv[i] = '0; ra[i] = '0; rb[i] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset%0d/flags", i), {29'b0, ir[i], ov[i], bz[i]}, 32'b100);
      check($sformatf("reset%0d/rd", i), rdv[i], 32'h0);
    end

    // Directed cases on both instances
    for (int s = 0; s < 2; s++) begin
      run_op(s, 3'd1, 32'h8000_0000, 32'h8000_0000, "mulh_min");
      run_op(s, 3'd0, 32'h8000_0000, 32'h8000_0000, "mul_min");
      run_op(s, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_ones");
      run_op(s, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_ones");
      run_op(s, 3'd4, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
      run_op(s, 3'd6, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
      run_op(s, 3'd7, 32'd7, 32'd2, "remu_7_2");
      run_op(s, 3'd4, 32'd5, 32'd0, "div_by0");
      run_op(s, 3'd4, 32'hFFFF_FFF9, 32'd0, "div_neg_by0");
      run_op(s, 3'd6, 32'd5, 32'd0, "rem_by0");
      run_op(s, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
      run_op(s, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
      run_op(s, 3'd0, 32'd0, 32'h1234_5678, "mul_zero");
    end

    // Hold out_ready low in DONE for 5 cycles
    start_and_wait(3'd3, 32'h0001_0000, 32'h0003_0000, 1);
    seen = 1;
    while (!ov[0] && seen < 100) begin
      @(posedge clk);
      @(negedge clk);
      seen++;
    end
    check("hold/latency", seen, 34);
    hold_rd = rdv[0];
    check("hold/rd", hold_rd, ref_res(3'd3, 32'h0001_0000, 32'h0003_0000));
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("hold/c%0d/ov_ir", k), {30'b0, ov[0], ir[0]}, 32'b10);
      check($sformatf("hold/c%0d/rd", k), rdv[0], hold_rd);
    end
    ordy[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ordy[0] = 1'b0;
    check("hold/release", {30'b0, ov[0], ir[0]}, 32'b01);

    // Flush at CALC cycle 10
    start_and_wait(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 10);
    check("flush/busy_before", {31'b0, bz[0]}, 32'd1);
    fl[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    fl[0] = 1'b0;
    check("flush/idle", {29'b0, ir[0], bz[0], ov[0]}, 32'b100);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (ov[0]) seen++;
    end
    check("flush/no_out_valid", seen, 0);
    run_op(0, 3'd3, 32'd3, 32'd5, "flush/mulhu_3_5");

    // Reset at CALC cycle 10
    start_and_wait(3'd4, 32'hDEAD_BEEF, 32'd17, 10);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst/idle", {29'b0, ir[0], bz[0], ov[0]}, 32'b100);
    check("rst/rd", rdv[0], 32'h0);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (ov[0]) seen++;
    end
    check("rst/no_out_valid", seen, 0);
    run_op(0, 3'd3, 32'd3, 32'd5, "rst/mulhu_3_5");

    // Flush in IDLE blocks acceptance
    @(negedge clk);
    iv[0] = 1'b1; fl[0] = 1'b1; opv[0] = 3'd0; ra[0] = 32'd9; rb[0] = 32'd9;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0; fl[0] = 1'b0;
    check("flush_idle/not_accepted", {30'b0, bz[0], ov[0]}, 32'b00);

    // Flush in DONE wins over out_ready, result withdrawn
    start_and_wait(3'd5, 32'd100, 32'd0, 1);
    check("flush_done/ov", {31'b0, ov[0]}, 32'd1);
    fl[0] = 1'b1; ordy[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    fl[0] = 1'b0; ordy[0] = 1'b0;
    check("flush_done/idle", {29'b0, ir[0], bz[0], ov[0]}, 32'b100);

    // Random ops on both instances, biased towards the special cases
    for (int i = 0; i < 30; i++) begin
      o = 3'($urandom_range(7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(7))
        0: b = 32'h0;
        1: a = 32'h0;
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: a = a >> $urandom_range(31);
        4: b = b >> $urandom_range(31);
        default: ;
      endcase
      run_op(0, o, a, b, $sformatf("rnd%0d/fast", i));
      run_op(1, o, a, b, $sformatf("rnd%0d/slow", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_iter.md
Name: muldiv_iter

Overview:
- Iterative, parametrised successor to the combinational M-extension unit.
- Executes all eight RV32M/RV64M ops (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) over multiple cycles using one shift-add/restoring-subtract datapath.
- Sits in the execute stage beside the ALU. The pipeline stalls on in_ready/out_valid.
- Adds over the previous unit: valid/ready handshake, flush, and RISC-V-mandated divide-by-zero and overflow results.

Parameters:
XLEN, 32, operand/result width in bits (32 or 64)
EARLY_OUT, 1, when 1, ops with a zero operand, div-by-zero or signed overflow complete without iterating

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in_valid  input  1  request valid
in_ready  output  1  unit idle and able to accept
op  input  mul_op_t  operation; encoding 0..7 = MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
r1  input  XLEN  rs1 operand
r2  input  XLEN  rs2 operand
flush  input  1  abandon in-flight op (branch mispredict/trap)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
rd  output  XLEN  result
busy  output  1  state != IDLE

Behaviour:
- Reset: synchronous, active-high, on clk rising edge. state=IDLE, out_valid=0, rd=0, busy=0, in_ready=1, counter=0. Reset mid-operation discards the op with no output.
- States: IDLE, CALC, FIX, DONE.
- Accept: in_valid && in_ready in IDLE.
  - Latch op and operand magnitudes.
  - Latch sign flags:
    - MULH: s1, s2 from operand MSBs.
    - MULHSU: s1 only.
    - DIV/REM: s1, s2.
    - Unsigned ops: none.
  - Go to CALC with counter=XLEN.
- CALC: one bit per cycle, counter decrements.
  - Multiply: 2*XLEN accumulator, shift-add on multiplier LSB.
  - Divide: restoring shift-subtract, giving quotient and remainder.
  - counter==1 -> FIX.
- FIX: apply sign correction by two's-complement negation.
  - Product negated if sign differs.
  - Quotient negated if s1^s2.
  - Remainder takes the sign of the dividend (s1).
  - Select the result:
    - MUL: product[XLEN-1:0].
    - MULH, MULHSU, MULHU: product[2*XLEN-1:XLEN].
    - DIV, DIVU: quotient.
    - REM, REMU: remainder.
  - Register rd. Next state DONE.
- DONE: out_valid=1, rd stable. On out_ready -> IDLE, out_valid drops the next cycle.
  - in_ready is 0 in DONE. No back-to-back overlap; a new accept happens one cycle after result handoff.
- Latency: accept at cycle 0, out_valid at cycle XLEN+2 (34 for XLEN=32).
- Special cases, checked at accept (when EARLY_OUT=1, go straight to DONE, out_valid at cycle 1):
  - Div by zero (r2==0):
    - DIV/DIVU: rd = all ones.
    - REM/REMU: rd = r1.
  - Signed overflow (DIV/REM with r1 = most-negative, r2 = all ones):
    - DIV: rd = r1.
    - REM: rd = 0.
  - Multiply with either operand zero: rd = 0.
  - With EARLY_OUT=0: identical results, normal latency.
- Flush:
  - In CALC/FIX/DONE -> IDLE next cycle, out_valid=0, no result.
  - Flush in IDLE blocks acceptance that cycle.
  - Flush has priority over out_ready.
- rd holds its last value outside DONE; the consumer must qualify it with out_valid.

Test Plan:
- XLEN=32, MULH r1=0x80000000, r2=0x80000000 -> rd=0x40000000, out_valid at cycle 34; MUL same operands -> 0x00000000.
- MULHSU r1=0xFFFFFFFF, r2=0xFFFFFFFF -> 0xFFFFFFFF; MULHU same operands -> 0xFFFFFFFE.
- DIV r1=-7 (0xFFFFFFF9), r2=2 -> rd=0xFFFFFFFD (-3); REM same operands -> 0xFFFFFFFF (-1); REMU 7,2 -> 1.
- DIV r1=5, r2=0 -> 0xFFFFFFFF; REM r1=5, r2=0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same -> 0. With EARLY_OUT=1, out_valid at cycle 1.
- Hold out_ready=0 for 5 cycles in DONE -> out_valid and rd stable, in_ready=0; then out_ready=1 -> IDLE and in_ready=1 next cycle.
- Assert flush at CALC cycle 10, and separately assert rst at cycle 10 -> out_valid never asserts, IDLE next cycle; a following MULHU 3×5 -> rd=0.
